// File: rtl/pg_domain_sequencer.sv
// Round-robin power-gating sequencer: runs one domain on/off transition at a time with a guard gap.
// Latency: want_on change -> request two cycles later; request drops the cycle after ack or timeout.
// Backpressure: pending domains wait as eligible bits; a silent controller is cut off after ACK_TIMEOUT.
module pg_domain_sequencer #(
  parameter int N_DOM         = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int ACK_TIMEOUT   = 64,
  parameter int IDXW          = (N_DOM > 2) ? $clog2(N_DOM) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DOM-1:0] want_on,
  input  logic [N_DOM-1:0] pgc_on_ack,
  input  logic [N_DOM-1:0] pgc_off_ack,
  input  logic [N_DOM-1:0] err_clr,
  output logic [N_DOM-1:0] pgc_on_req,
  output logic [N_DOM-1:0] pgc_off_req,
  output logic [N_DOM-1:0] dom_on,
  output logic [N_DOM-1:0] dom_err,
  output logic             busy,
  output logic [IDXW-1:0]  grant_idx
);

  localparam int CW = $clog2(ACK_TIMEOUT);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [SW-1:0] ST_LOAD = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_SETTLE} state_t;

  state_t           state, state_d;
  logic [N_DOM-1:0] want_q;
  logic [N_DOM-1:0] elig;
  logic [N_DOM-1:0] req_vec;
  logic [N_DOM-1:0] err_set;
  logic [IDXW-1:0]  rr_ptr;
  logic [IDXW-1:0]  rr_next;
  logic [IDXW-1:0]  pick;
  logic [IDXW-1:0]  kk;
  logic             found;
  logic             dir_q;
  logic             ack_hit;
  logic             timeout_hit;
  logic [CW-1:0]    wait_cnt;
  logic [SW-1:0]    settle_cnt;
  int               k;

  // A domain needs work when its target differs from its confirmed state and it is not faulted.
  assign elig        = (want_q ^ dom_on) & ~dom_err;
  assign req_vec     = {{(N_DOM-1){1'b0}}, 1'b1} << grant_idx;
  assign ack_hit     = dir_q ? pgc_on_ack[grant_idx] : pgc_off_ack[grant_idx];
  assign timeout_hit = (wait_cnt == TO_LAST);
  assign rr_next     = (grant_idx == IDXW'(N_DOM - 1)) ? '0 : grant_idx + 1'b1;
  assign err_set     = (state == S_WAIT_ACK && timeout_hit && !ack_hit) ? req_vec : '0;

  // Round-robin search: first eligible domain at or above rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    k     = 0;
    kk    = '0;
    for (int j = 0; j < N_DOM; j++) begin
      k = int'(rr_ptr) + j;
      if (k >= N_DOM) k = k - N_DOM;
      kk = IDXW'(k);
      if (!found && elig[kk]) begin
        found = 1'b1;
        pick  = kk;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state and request/busy decode; only the granted domain's request is ever driven.
  always_comb begin
    state_d     = state;
    busy        = 1'b0;
    pgc_on_req  = '0;
    pgc_off_req = '0;
    case (state)
      S_IDLE: begin
        if (found) state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        busy = 1'b1;
        if (dir_q) pgc_on_req  = req_vec;
        else       pgc_off_req = req_vec;
        if (ack_hit || timeout_hit)
          state_d = (SETTLE_CYCLES == 0) ? S_IDLE : S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grant capture, wait/settle counters, confirmed state and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      want_q     <= '0;
      dom_on     <= '0;
      dom_err    <= '0;
      rr_ptr     <= '0;
      grant_idx  <= '0;
      dir_q      <= 1'b0;
      wait_cnt   <= '0;
      settle_cnt <= '0;
    end else begin
      want_q  <= want_on;
      dom_err <= (dom_err & ~err_clr) | err_set;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant_idx <= pick;
            dir_q     <= want_q[pick];
            wait_cnt  <= '0;
          end
        end
        S_WAIT_ACK: begin
          if (ack_hit || timeout_hit) begin
            if (ack_hit) dom_on[grant_idx] <= dir_q;
            rr_ptr     <= rr_next;
            settle_cnt <= ST_LOAD;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pg_domain_sequencer.sv
// Bench for pg_domain_sequencer: directed scenarios plus randomized traffic against a timeline model.
// Latency: model predicts every output each cycle; compares on the falling edge.
// Backpressure: emulated controllers ack after a per-domain delay, or never.
module tb_pg_domain_sequencer;
  localparam int N   = 4;
  localparam int ST  = 8;
  localparam int TO  = 64;
  localparam int IW  = 2;
  localparam int INF = 1000000000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  want_on = '0, pgc_on_ack = '0, pgc_off_ack = '0, err_clr = '0;
  logic [N-1:0]  pgc_on_req, pgc_off_req, dom_on, dom_err;
  logic          busy;
  logic [IW-1:0] grant_idx;

  always #5 clk = ~clk;

  pg_domain_sequencer #(.N_DOM(N), .SETTLE_CYCLES(ST), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .want_on(want_on), .pgc_on_ack(pgc_on_ack),
    .pgc_off_ack(pgc_off_ack), .err_clr(err_clr), .pgc_on_req(pgc_on_req),
    .pgc_off_req(pgc_off_req), .dom_on(dom_on), .dom_err(dom_err),
    .busy(busy), .grant_idx(grant_idx)
  );

  int n_tests = 0, n_fail = 0, tcyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Emulated controllers: ack once the request has been high for more than dly cycles (dly<0: never).
  int dly[N];
  int hi_on[N], hi_off[N];
  bit noise_en = 1'b0;
  initial begin
    for (int i = 0; i < N; i++) begin dly[i] = 2; hi_on[i] = 0; hi_off[i] = 0; end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        hi_on[i]  = pgc_on_req[i]  ? hi_on[i] + 1  : 0;
        hi_off[i] = pgc_off_req[i] ? hi_off[i] + 1 : 0;
        pgc_on_ack[i]  = (pgc_on_req[i]  && dly[i] >= 0 && hi_on[i]  > dly[i]) ||
                         (noise_en && $urandom_range(0, 15) == 0);
        pgc_off_ack[i] = (pgc_off_req[i] && dly[i] >= 0 && hi_off[i] > dly[i]) ||
                         (noise_en && $urandom_range(0, 15) == 0);
      end
    end
  end

  // Timeline model: a transaction is a request window [m_from, m_end) and a busy window [m_from, m_free).
  int m_cyc = 0, m_g = 0, m_from = 0, m_end = 0, m_free = 0, m_rr = 0, k = 0;
  bit m_open = 1'b0, m_dir = 1'b0, idle = 1'b0, hit = 1'b0, set_err = 1'b0, took = 1'b0;
  logic [N-1:0]  m_on = '0, m_err = '0, m_want_q = '0;
  logic [IW-1:0] m_grant = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_open = 1'b0; m_rr = 0; m_on = '0; m_err = '0; m_want_q = '0; m_grant = '0;
    end else begin
      idle = !m_open || (m_cyc >= m_free);
      set_err = 1'b0;
      took = 1'b0;
      if (idle) begin
        for (int j = 0; j < N; j++) begin
          k = (m_rr + j) % N;
          if (!took && m_want_q[k] != m_on[k] && !m_err[k]) begin
            took = 1'b1; m_open = 1'b1; m_g = k; m_dir = m_want_q[k];
            m_from = m_cyc + 1; m_end = INF; m_free = INF; m_grant = IW'(k);
          end
        end
      end else if (m_cyc >= m_from && m_cyc < m_end) begin
        hit = m_dir ? pgc_on_ack[m_g] : pgc_off_ack[m_g];
        if (hit || (m_cyc - m_from == TO - 1)) begin
          m_end  = m_cyc + 1;
          m_free = m_cyc + 1 + ST;
          if (hit) m_on[m_g] = m_dir;
          else     set_err = 1'b1;
          m_rr = (m_g + 1) % N;
        end
      end
      m_err = m_err & ~err_clr;
      if (set_err) m_err[m_g] = 1'b1;
      m_want_q = want_on;
    end
    m_cyc++;
  end

  // Per-cycle comparison against the model.
  logic [N-1:0] exp_req;
  bit           in_req, exp_busy;
  always @(negedge clk) begin
    if (chk_en) begin
      in_req   = m_open && m_cyc >= m_from && m_cyc < m_end;
      exp_busy = m_open && m_cyc >= m_from && m_cyc < m_free;
      exp_req  = in_req ? (N'(1) << m_g) : '0;
      chk("cyc_on_req",  pgc_on_req,  m_dir ? exp_req : '0);
      chk("cyc_off_req", pgc_off_req, m_dir ? '0 : exp_req);
      chk("cyc_dom_on",  dom_on,  m_on);
      chk("cyc_dom_err", dom_err, m_err);
      chk("cyc_busy",    busy,    exp_busy);
      chk("cyc_grant",   grant_idx, m_grant);
      chk("cyc_one_req", ($countones(pgc_on_req | pgc_off_req) <= 1), 1);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    tcyc++;
  endtask

  task automatic wait_req(input int bound, output int idx);
    idx = -1;
    for (int t = 0; t < bound && idx < 0; t++) begin
      for (int i = 0; i < N; i++) if (pgc_on_req[i] || pgc_off_req[i]) idx = i;
      if (idx < 0) tick();
    end
    if (idx < 0) begin
      n_tests++; n_fail++;
      $display("FAIL wait_req: no request within %0d cycles", bound);
    end
  endtask

  task automatic wait_req_low(input int bound);
    for (int t = 0; t < bound && (|(pgc_on_req | pgc_off_req)); t++) tick();
    chk("req_drops", |(pgc_on_req | pgc_off_req), 0);
  endtask

  task automatic wait_quiet(input int bound);
    int lo;
    lo = 0;
    for (int t = 0; t < bound && lo < 4; t++) begin
      lo = busy ? 0 : lo + 1;
      tick();
    end
    chk("quiet_reached", (lo >= 4), 1);
  endtask

  int idx, hc, t_prev;

  initial begin
    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (3) tick();
    chk("rst_on_req", pgc_on_req, 0);
    chk("rst_off_req", pgc_off_req, 0);
    chk("rst_dom_on", dom_on, 0);
    chk("rst_dom_err", dom_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_idx, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Single power-on, ack 3 cycles after request.
    dly[0] = 3;
    want_on = 4'b0001;
    tick(); chk("lat_k1_idle", pgc_on_req, 0);
    tick(); chk("lat_k2_req", pgc_on_req, 4'b0001);
    hc = 0;
    while (pgc_on_req[0] && hc < 100) begin hc++; tick(); end
    chk("req0_width", hc, 4);
    chk("settle_busy_start", busy, 1);
    chk("dom_on_0001", dom_on, 4'b0001);
    repeat (7) tick();
    chk("settle_busy_end", busy, 1);
    tick();
    chk("idle_after_settle", busy, 0);

    // All four on from all-off, ack after 2 cycles.
    want_on = '0;
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    for (int i = 0; i < N; i++) dly[i] = 2;
    want_on = 4'b1111;
    t_prev = 0;
    for (int d = 0; d < N; d++) begin
      wait_req(100, idx);
      chk("order_all_on", idx, d);
      if (d > 0) chk("rise_spacing", tcyc - t_prev, 12);
      t_prev = tcyc;
      wait_req_low(100);
    end
    wait_quiet(200);
    chk("all_on", dom_on, 4'b1111);

    // Fairness: bring rr_ptr to 2, then make domains 0 and 3 eligible together.
    want_on = 4'b1101;
    wait_quiet(200);
    want_on = 4'b0100;
    wait_req(100, idx); chk("fair_first", idx, 3); wait_req_low(100);
    wait_req(100, idx); chk("fair_second", idx, 0);
    wait_quiet(200);
    chk("fair_dom_on", dom_on, 4'b0100);

    // Timeout on domain 1, skip while faulted, retry after clear.
    dly[1] = -1;
    want_on = 4'b0110;
    wait_req(100, idx); chk("to_idx", idx, 1);
    hc = 0;
    while (pgc_on_req[1] && hc < 200) begin hc++; tick(); end
    chk("to_req_width", hc, 64);
    chk("to_err_set", dom_err, 4'b0010);
    chk("to_dom_on", dom_on, 4'b0100);
    wait_quiet(200);
    want_on = 4'b1110;
    wait_req(100, idx); chk("skip_faulted", idx, 3);
    wait_quiet(200);
    chk("skip_dom_on", dom_on, 4'b1100);
    dly[1] = 2;
    err_clr = 4'b0010; tick(); err_clr = '0;
    chk("err_cleared", dom_err, 0);
    wait_req(100, idx); chk("retry_idx", idx, 1);
    wait_quiet(200);
    chk("retry_dom_on", dom_on, 4'b1110);

    // Reversal mid-transaction: power-on completes, power-off follows.
    want_on = 4'b1010;
    wait_quiet(200);
    dly[2] = 10;
    want_on = 4'b1110;
    wait_req(100, idx); chk("rev_on_req", pgc_on_req, 4'b0100);
    repeat (3) tick();
    want_on = 4'b1010;
    wait_req_low(100);
    chk("rev_on_done", dom_on, 4'b1110);
    wait_req(100, idx); chk("rev_off_req", pgc_off_req, 4'b0100);
    wait_quiet(200);
    chk("rev_final", dom_on, 4'b1010);

    // Asynchronous reset in the middle of a wait.
    for (int i = 0; i < N; i++) dly[i] = -1;
    want_on = 4'b1111;
    wait_req(100, idx);
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_req", pgc_on_req | pgc_off_req, 0);
    chk("arst_dom_on", dom_on, 0);
    chk("arst_busy", busy, 0);
    tick(); rst = 1'b0;
    for (int i = 0; i < N; i++) dly[i] = 2;
    wait_req(100, idx); chk("arst_restart_0", idx, 0);
    wait_quiet(300);
    chk("arst_final", dom_on, 4'b1111);

    // Randomized traffic with spurious acks, stalls and error clears.
    noise_en = 1'b1;
    for (int it = 0; it < 2500; it++) begin
      tick();
      if ($urandom_range(0, 11) == 0) want_on = N'($urandom);
      if (err_clr != '0) err_clr = '0;
      else if ($urandom_range(0, 39) == 0) err_clr = N'($urandom);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 49) == 0)
          dly[i] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
    end
    noise_en = 1'b0;
    err_clr = '0;
    for (int i = 0; i < N; i++) dly[i] = 1;
    repeat (3) tick();
    err_clr = '1; tick(); err_clr = '0;
    wait_quiet(3000);
    chk("final_tracks_want", dom_on, want_on);
    chk("final_no_err", dom_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
